// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC generation, in-order req/gnt/rvalid word fetches and a prefetch FIFO
// feeding the IR stage. Defining IFU_PERF_CNT_EN adds grant and stall performance counters.
module ifu_fetch #(
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_flag_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_gnt_i,
  input  logic        ibus_rvalid_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] ins_o,
  output logic [31:0] ins_addr_o,
  output logic        ins_valid_o,
  output logic [31:0] perf_fetch_cnt_o,
  output logic [31:0] perf_stall_cnt_o
);

  localparam logic [31:0] INS_NOP    = 32'h0000_0013;
  localparam logic [31:0] RESET_ADDR = RESET_PC;
  // The issued-address queue also tracks fetches being discarded after a jump,
  // so it holds up to two credit windows.
  localparam int AQ_DEPTH = 2 * FIFO_DEPTH;
  localparam int FW       = $clog2(FIFO_DEPTH);
  localparam int AW       = $clog2(AQ_DEPTH);
  localparam int CW       = AW + 1;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } fetch_entry_t;

  fetch_entry_t  fifo_q [FIFO_DEPTH];
  logic [FW-1:0] fifo_rd_q, fifo_wr_q;
  logic [FW:0]   fifo_cnt_q;
  logic [31:0]   aq_q [AQ_DEPTH];
  logic [AW-1:0] aq_rd_q, aq_wr_q;
  logic [CW-1:0] inflight_q, discard_q;
  logic [31:0]   pc_q;

  logic [CW-1:0] credit_used, outstanding;
  logic          fifo_empty, gnt_fire, rv_drop, rv_keep, rv_pop, fifo_push, fifo_pop;
  logic          jump_addr_unused;

  assign credit_used = inflight_q + CW'(fifo_cnt_q);
  assign outstanding = inflight_q + discard_q;
  assign fifo_empty  = (fifo_cnt_q == '0);

  // Held low while in reset so no request leaks onto the bus before the first clock.
  assign ibus_req_o  = rst_n && (credit_used < CW'(FIFO_DEPTH)) && (outstanding < CW'(AQ_DEPTH));
  assign ibus_addr_o = pc_q;

  assign gnt_fire  = ibus_req_o && ibus_gnt_i;
  assign rv_drop   = ibus_rvalid_i && (discard_q != '0);
  assign rv_keep   = ibus_rvalid_i && (discard_q == '0) && (inflight_q != '0);
  assign rv_pop    = rv_drop || rv_keep;
  assign fifo_push = rv_keep && !jump_flag_i;
  assign fifo_pop  = !fifo_empty && !hold_flag_i && !jump_flag_i;

  assign ins_valid_o = !fifo_empty;
  assign ins_o       = fifo_empty ? INS_NOP    : fifo_q[fifo_rd_q].data;
  assign ins_addr_o  = fifo_empty ? RESET_ADDR : fifo_q[fifo_rd_q].addr;

  assign jump_addr_unused = ^jump_addr_i[1:0];

  // NOTE: storage arrays carry no reset; pointers and counts make stale contents unobservable.
  always_ff @(posedge clk) begin
    if (gnt_fire) aq_q[aq_wr_q] <= pc_q;
    if (fifo_push) fifo_q[fifo_wr_q] <= '{addr: aq_q[aq_rd_q], data: ibus_rdata_i};
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      fifo_rd_q  <= '0;
      fifo_wr_q  <= '0;
      fifo_cnt_q <= '0;
      aq_rd_q    <= '0;
      aq_wr_q    <= '0;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      if (gnt_fire) aq_wr_q <= aq_wr_q + 1'b1;
      if (rv_pop)   aq_rd_q <= aq_rd_q + 1'b1;
      if (jump_flag_i) begin
        pc_q       <= {jump_addr_i[31:2], 2'b00};
        fifo_rd_q  <= '0;
        fifo_wr_q  <= '0;
        fifo_cnt_q <= '0;
        inflight_q <= '0;
        // Everything still on the bus, including a grant taken this cycle, belongs to the old path.
        discard_q  <= outstanding + CW'(gnt_fire) - CW'(rv_pop);
      end else begin
        if (gnt_fire)  pc_q      <= pc_q + 32'd4;
        if (fifo_push) fifo_wr_q <= fifo_wr_q + 1'b1;
        if (fifo_pop)  fifo_rd_q <= fifo_rd_q + 1'b1;
        fifo_cnt_q <= fifo_cnt_q + (FW+1)'(fifo_push) - (FW+1)'(fifo_pop);
        inflight_q <= inflight_q + CW'(gnt_fire) - CW'(rv_keep);
        discard_q  <= discard_q - CW'(rv_drop);
      end
    end
  end

`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetch_q, perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (gnt_fire) perf_fetch_q <= perf_fetch_q + 32'd1;
      if (fifo_empty && !jump_flag_i) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_fetch_cnt_o = perf_fetch_q;
  assign perf_stall_cnt_o = perf_stall_q;
`else
  assign perf_fetch_cnt_o = '0;
  assign perf_stall_cnt_o = '0;
`endif

endmodule
